// File: rtl/rd53_cmd_lane_driver_if.sv
// Command-frame push interface for rd53_cmd_lane_driver: valid/ready handshake carrying one
// 16-bit frame, its lane mask and the end-of-command flag.
interface rd53_cmd_lane_driver_if #(
  parameter int unsigned NUM_CH = 4
) ();
  logic              s_valid;
  logic              s_ready;
  logic [15:0]       s_data;
  logic [NUM_CH-1:0] s_mask;
  logic              s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_mask,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_mask,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/rd53_cmd_lane_driver.sv
// Frame-aligned multi-lane RD53 command serialiser with a shared command FIFO and periodic SYNC.
// Optional macro RD53_CMD_LANE_INVERT_EN adds per-lane output polarity inversion (lane_invert).
module rd53_cmd_lane_driver #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_PERIOD = 32,
  parameter logic [15:0] SYNC_WORD   = 16'h817E,
  parameter logic [15:0] NOOP_WORD   = 16'h6969
) (
  input  logic                        clk,
  input  logic                        rstL,
  input  logic                        enable,
  rd53_cmd_lane_driver_if.slave       s,
`ifdef RD53_CMD_LANE_INVERT_EN
  input  logic [NUM_CH-1:0]           lane_invert,
`endif
  output logic [NUM_CH-1:0]           cmd_out,
  output logic                        frame_start,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        underflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(SYNC_PERIOD);
  localparam int unsigned EW = 17 + NUM_CH;
  localparam logic [CW-1:0] DepthCnt = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] SyncLast = SW'(SYNC_PERIOD - 1);

  typedef enum logic {StIdle, StInCmd} state_e;
  typedef enum logic [1:0] {SelSync, SelCmd, SelNoop} sel_e;

  state_e            r_state, w_state_next;
  sel_e              w_sel;
  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [SW-1:0]     r_sync_cnt;
  logic [3:0]        r_bit_cnt;
  logic              r_first, r_underflow, r_frame_start;
  logic [15:0]       r_shift [NUM_CH];
  logic [NUM_CH-1:0] r_cmd_out;
  logic [15:0]       w_frame [NUM_CH];
  logic              w_load, w_push, w_pop, w_ready;
  logic [EW-1:0]     w_head;
  logic              w_head_last;
  logic [NUM_CH-1:0] w_head_mask;
  logic [15:0]       w_head_data;

  // Ready is held low throughout reset so nothing is accepted before the first frame.
  assign w_ready     = rstL && (r_count < DepthCnt);
  assign s.s_ready   = w_ready;
  assign w_push      = s.s_valid && w_ready;
  assign w_load      = r_first || (r_bit_cnt == 4'd0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_last = w_head[EW-1];
  assign w_head_mask = w_head[16 +: NUM_CH];
  assign w_head_data = w_head[15:0];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {s.s_last, s.s_mask, s.s_data};
  end

  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Command-tracking FSM: state register.
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Next state: only a popped frame changes whether a command is open.
  always_comb begin
    w_state_next = r_state;
    if (w_load && (w_sel == SelCmd)) w_state_next = w_head_last ? StIdle : StInCmd;
  end

  // Frame selection: an open command defers SYNC and keeps popping even with enable low.
  always_comb begin
    w_sel = SelNoop;
    w_pop = 1'b0;
    if ((r_sync_cnt == SyncLast) && (r_state == StIdle)) begin
      w_sel = SelSync;
    end else if ((enable || (r_state == StInCmd)) && (r_count != '0)) begin
      w_sel = SelCmd;
      w_pop = w_load;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_frame[i] = NOOP_WORD;
      if (w_sel == SelSync)                         w_frame[i] = SYNC_WORD;
      else if ((w_sel == SelCmd) && w_head_mask[i]) w_frame[i] = w_head_data;
    end
  end

  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      r_first       <= 1'b1;
      r_bit_cnt     <= 4'd15;
      r_sync_cnt    <= SyncLast;
      r_underflow   <= 1'b0;
      r_frame_start <= 1'b0;
      r_cmd_out     <= '0;
      for (int i = 0; i < NUM_CH; i++) r_shift[i] <= '0;
    end else begin
      r_first       <= 1'b0;
      // Fresh frame sits in the shifters while bit_cnt is 15; its MSB reaches cmd_out next.
      r_frame_start <= (r_bit_cnt == 4'd15) && !r_first;
      r_bit_cnt     <= w_load ? 4'd15 : r_bit_cnt - 4'd1;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cmd_out[i] <= r_shift[i][15];
        r_shift[i]   <= w_load ? w_frame[i] : {r_shift[i][14:0], 1'b0};
      end
      if (w_load) begin
        if (w_sel == SelSync)            r_sync_cnt <= '0;
        else if (r_sync_cnt != SyncLast) r_sync_cnt <= r_sync_cnt + 1'b1;
        if ((w_sel == SelNoop) && (r_state == StInCmd)) r_underflow <= 1'b1;
      end
    end
  end

`ifdef RD53_CMD_LANE_INVERT_EN
  assign cmd_out = r_cmd_out ^ lane_invert;
`else
  assign cmd_out = r_cmd_out;
`endif
  assign frame_start = r_frame_start;
  assign fifo_count  = r_count;
  assign underflow   = r_underflow;

endmodule

// File: doc/rd53_cmd_lane_driver.md
Name: rd53_cmd_lane_driver

Overview:
Parametrised multi-chip command-stream driver for RD53-family simulation benches and firmware. Serialises 16-bit command frames MSB-first, one bit per clk (160 Mb/s), onto NUM_CH independent CMD lanes. Lanes are frame-aligned and share one command FIFO; a per-frame channel mask selects which lanes carry the command, and all other lanes carry NOOP. Periodic SYNC frames are inserted automatically, and a multi-frame command is never split by a SYNC.

Parameters:
NUM_CH, 4, number of chip CMD lanes (1..16)
FIFO_DEPTH, 16, command FIFO entries; power of two, >=2
SYNC_PERIOD, 32, frames between forced SYNC frames; >=2
SYNC_WORD, 16'h817E, sync frame pattern
NOOP_WORD, 16'h6969, idle frame pattern

Ports:
clk  in  1  160 MHz command clock
rstL  in  1  asynchronous reset, active low
enable  in  1  1 = FIFO frames may be popped; 0 = only SYNC/NOOP are sent
s_valid  in  1  command frame valid
s_ready  out  1  FIFO not full
s_data  in  16  command frame
s_mask  in  NUM_CH  lane select for this frame
s_last  in  1  frame is the final frame of its command
cmd_out  out  NUM_CH  serial command bit per lane
frame_start  out  1  pulses for one cycle when bit 15 of a new frame is on cmd_out
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
underflow  out  1  sticky: NOOP inserted mid-command; cleared only by reset

Behaviour:
- Reset (async assert, sync deassert): cmd_out=0, frame_start=0, s_ready=0 while rstL=0, fifo_count=0, underflow=0, bit_cnt=15, sync_cnt=SYNC_PERIOD-1, in_cmd=0.
- FIFO: push when s_valid&&s_ready, storing {s_last,s_mask,s_data}. s_ready=(fifo_count<FIFO_DEPTH). A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Bit counter: counts 15 down to 0. On the cycle with bit_cnt==0 (or the first cycle after reset), the next frame is loaded into the per-lane shift registers and bit_cnt returns to 15.
- cmd_out[i] is registered from shift_reg[i][15]. The frame bit therefore appears one cycle after load. frame_start is asserted in the same cycle as the MSB.
- Frame selection at load, in priority order:
  1. SEND_SYNC: sync_cnt==SYNC_PERIOD-1 and in_cmd==0 -> SYNC_WORD on all lanes; sync_cnt=0.
  2. SEND_CMD: enable && fifo_count>0 -> pop one entry. Lanes with mask=1 get s_data; others get NOOP_WORD. in_cmd=!last. sync_cnt increments, saturating at SYNC_PERIOD-1.
  3. SEND_NOOP: NOOP_WORD on all lanes; sync_cnt increments (saturating). If in_cmd==1 at this point, underflow is set.
- Sync deferral: while in_cmd==1 a due SYNC is held off. Popping continues regardless of enable until the frame with last=1 completes, and the SYNC is sent at the next load.
- First frame after reset is always SYNC.
- Mask = all zeros: the entry is still popped and every lane sends NOOP.
- Deasserting enable mid-command does not stall the command. enable gates only the start of a new command.
- Reset mid-frame aborts the frame immediately; FIFO contents are discarded.

Optional Feature:
RD53_CMD_LANE_INVERT_EN: when defined, adds input lane_invert[NUM_CH-1:0]. cmd_out[i] becomes the registered bit XOR lane_invert[i], compensating for P/N swaps on the board. Reset value of cmd_out is then lane_invert. When undefined, the port is absent and the output is unmodified.

Test Plan:
- Release reset with FIFO empty, enable=1 -> frame_start every 16 cycles; first frame 0x817E on all lanes; next 31 frames 0x6969; frame 33 is 0x817E.
- Push 0x5A5A with mask=4'b0101, last=1 -> lanes 0 and 2 serialise 0101101001011010; lanes 1 and 3 send 0x6969 in the same frame.
- Push a 3-frame command (last=0,0,1) timed so SYNC falls due after frame 1 -> all 3 frames are sent contiguously, then 0x817E; underflow stays 0.
- Push frame 1 (last=0) only, then starve the FIFO -> the next frame is 0x6969 and underflow=1 until reset.
- Push 16 frames with enable=0 -> fifo_count=16, s_ready=0, 17th push is ignored. Then set enable=1 -> count decrements by 1 per 16 cycles, and s_ready rises the cycle after the first pop.
- Assert rstL=0 at bit 7 of a command frame -> cmd_out=0 within the same cycle, fifo_count=0; after release the first frame is 0x817E.
